// File: rtl/match_issue_arbiter.sv
// Arbitrates between inserting network messages into the unexpected queue and
// issuing host receive searches, with burst limiting and a search timeout.
module match_issue_arbiter #(
   parameter int PKT_WIDTH = 128,
   parameter int FIFO_AW   = 2,
   parameter int TIMEOUT   = 1100,
   parameter int MAX_BURST = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 net_valid,
   input  logic [PKT_WIDTH-1:0] net_message,
   output logic                 net_ready,
   input  logic                 req_valid,
   input  logic [31:0]          request,
   output logic                 req_ready,
   output logic                 insert,
   output logic                 find,
   output logic [PKT_WIDTH-1:0] message,
   output logic [31:0]          request_out,
   input  logic                 found,
   input  logic                 not_found,
   input  logic                 Q_full,
   input  logic [PKT_WIDTH-1:0] unexpected_message,
   output logic                 result_valid,
   output logic                 result_hit,
   output logic [PKT_WIDTH-1:0] result_message,
   output logic [31:0]          result_request,
   output logic                 timeout_err
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int PW    = FIFO_AW + 1;
   localparam int TW    = $clog2(TIMEOUT + 1);
   localparam int BW    = $clog2(MAX_BURST + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [BW-1:0] B_MAX  = BW'(MAX_BURST);

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      INS         = 3'd1,
      SETTLE      = 3'd2,
      FIND        = 3'd3,
      WAIT_RESULT = 3'd4
   } state_t;

   state_t state, next_state;

   logic [PKT_WIDTH-1:0] net_mem [DEPTH];
   logic [31:0]          req_mem [DEPTH];
   logic [PW-1:0]        net_wp, net_rp, req_wp, req_rp;
   logic                 net_full, net_empty, req_full, req_empty;
   logic                 net_push, net_pop, req_push, req_pop;
   logic [TW-1:0]        tcnt;
   logic [BW-1:0]        burst, eff_burst;

   // Full when pointers differ only in the wrap bit.
   function automatic logic ptr_full(input logic [PW-1:0] wp, input logic [PW-1:0] rp);
      return wp == {~rp[PW-1], rp[PW-2:0]};
   endfunction

   assign net_full  = ptr_full(net_wp, net_rp);
   assign req_full  = ptr_full(req_wp, req_rp);
   assign net_empty = (net_wp == net_rp);
   assign req_empty = (req_wp == req_rp);
   assign net_ready = ~net_full;
   assign req_ready = ~req_full;
   assign net_push  = net_valid & ~net_full;
   assign req_push  = req_valid & ~req_full;

   // FIFO storage, written on accepted pushes.
   always_ff @(posedge clk) begin
      if (net_push) net_mem[net_wp[PW-2:0]] <= net_message;
      if (req_push) req_mem[req_wp[PW-2:0]] <= request;
   end

   // Next-state decision; FIFO pops happen on the edge entering INS or FIND.
   always_comb begin
      next_state = state;
      net_pop    = 1'b0;
      req_pop    = 1'b0;
      eff_burst  = req_empty ? BW'(0) : burst;
      case (state)
         IDLE: begin
            if (!net_empty && !Q_full && (eff_burst < B_MAX)) begin
               next_state = INS;
               net_pop    = 1'b1;
            end else if (!req_empty) begin
               next_state = FIND;
               req_pop    = 1'b1;
            end else begin
               next_state = IDLE;
            end
         end
         INS:    next_state = SETTLE;
         SETTLE: next_state = IDLE;
         FIND:   next_state = WAIT_RESULT;
         WAIT_RESULT: begin
            if (found || not_found || (tcnt == T_LAST)) begin
               next_state = SETTLE;
            end else begin
               next_state = WAIT_RESULT;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // State, pointers, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         net_wp         <= PW'(0);
         net_rp         <= PW'(0);
         req_wp         <= PW'(0);
         req_rp         <= PW'(0);
         tcnt           <= TW'(0);
         burst          <= BW'(0);
         insert         <= 1'b0;
         find           <= 1'b0;
         message        <= {PKT_WIDTH{1'b0}};
         request_out    <= 32'd0;
         result_valid   <= 1'b0;
         result_hit     <= 1'b0;
         result_message <= {PKT_WIDTH{1'b0}};
         result_request <= 32'd0;
         timeout_err    <= 1'b0;
      end else begin
         state        <= next_state;
         insert       <= (next_state == INS);
         find         <= (next_state == FIND);
         result_valid <= 1'b0;
         if (net_push) net_wp <= net_wp + PW'(1);
         if (req_push) req_wp <= req_wp + PW'(1);
         if (net_pop) begin
            net_rp  <= net_rp + PW'(1);
            message <= net_mem[net_rp[PW-2:0]];
         end
         if (req_pop) begin
            req_rp      <= req_rp + PW'(1);
            request_out <= req_mem[req_rp[PW-2:0]];
         end
         if (req_pop || req_empty) begin
            burst <= BW'(0);
         end else if (net_pop && (burst < B_MAX)) begin
            burst <= burst + BW'(1);
         end
         if (req_pop) begin
            tcnt <= TW'(0);
         end else if (state == WAIT_RESULT) begin
            tcnt <= tcnt + TW'(1);
         end
         // Status has priority over a timeout landing in the same cycle.
         if (state == WAIT_RESULT) begin
            if (found) begin
               result_valid   <= 1'b1;
               result_hit     <= 1'b1;
               result_message <= unexpected_message;
               result_request <= request_out;
            end else if (not_found || (tcnt == T_LAST)) begin
               result_valid   <= 1'b1;
               result_hit     <= 1'b0;
               result_message <= {PKT_WIDTH{1'b0}};
               result_request <= request_out;
               if (!not_found) timeout_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_match_issue_arbiter.sv
// Directed self-checking bench for match_issue_arbiter.
module tb_match_issue_arbiter;

   localparam int PW = 128;
   localparam int TO = 1100;

   logic          clk = 1'b0;
   logic          rst;
   logic          net_valid, req_valid, found, not_found, Q_full;
   logic [PW-1:0] net_message, unexpected_message;
   logic [31:0]   request;
   logic          net_ready, req_ready, insert, find, result_valid, result_hit, timeout_err;
   logic [PW-1:0] message, result_message;
   logic [31:0]   request_out, result_request;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   localparam logic [PW-1:0] M1 = {16'hA5A5, 8'h01, 8'h02, 8'h03, 88'h0123456789ABCDEF012345};

   match_issue_arbiter #(.PKT_WIDTH(PW), .FIFO_AW(2), .TIMEOUT(TO), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst),
      .net_valid(net_valid), .net_message(net_message), .net_ready(net_ready),
      .req_valid(req_valid), .request(request), .req_ready(req_ready),
      .insert(insert), .find(find), .message(message), .request_out(request_out),
      .found(found), .not_found(not_found), .Q_full(Q_full),
      .unexpected_message(unexpected_message),
      .result_valid(result_valid), .result_hit(result_hit),
      .result_message(result_message), .result_request(result_request),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [PW-1:0] nm(input int k);
      return {64'hFEED_0000_0000_0000 + 64'(k), 64'(k * 3 + 1)};
   endfunction

   // which: 0 insert, 1 find, 2 result_valid; checks the current negedge first
   task automatic wait_sig(input int which, input int limit, output bit ok, output int at);
      ok = 1'b0;
      at = -1;
      for (int i = 0; i < limit; i++) begin
         if ((which == 0 && insert) || (which == 1 && find) || (which == 2 && result_valid)) begin
            ok = 1'b1;
            at = cyc;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; net_valid = 1'b0; req_valid = 1'b0; found = 1'b0; not_found = 1'b0;
      Q_full = 1'b0; net_message = '0; unexpected_message = '0; request = 32'd0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({insert, find, result_valid, result_hit, timeout_err} !== 5'd0) begin
         n_err++; $display("FAIL reset_strobes got=%b want=00000", {insert, find, result_valid, result_hit, timeout_err});
      end
      n_cmp++;
      if ({result_message, result_request, request_out} !== '0) begin
         n_err++; $display("FAIL reset_data got=%h/%h/%h want=0", result_message, result_request, request_out);
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({net_ready, req_ready} !== 2'b11) begin
         n_err++; $display("FAIL reset_ready got=%b want=11", {net_ready, req_ready});
      end
   endtask

   task automatic test_hit();
      bit ok; int ti, tf, tr;
      net_valid = 1'b1; net_message = M1;
      @(negedge clk);
      net_valid = 1'b0; req_valid = 1'b1; request = 32'h00010203;
      @(negedge clk);
      req_valid = 1'b0;
      wait_sig(0, 50, ok, ti);
      n_cmp++;
      if (!ok || message !== M1) begin
         n_err++; $display("FAIL hit_insert ok=%0d got=%h want=%h", ok, message, M1);
      end
      @(negedge clk);
      wait_sig(1, 50, ok, tf);
      n_cmp++;
      if (!ok || (tf - ti) < 2) begin
         n_err++; $display("FAIL hit_find_gap ok=%0d got=%0d want>=2", ok, tf - ti);
      end
      n_cmp++;
      if (request_out !== 32'h00010203) begin
         n_err++; $display("FAIL hit_request_out got=%h want=00010203", request_out);
      end
      @(negedge clk);
      found = 1'b1; unexpected_message = M1;
      @(negedge clk);
      found = 1'b0;
      n_cmp++;
      if ({result_valid, result_hit} !== 2'b11 || result_message !== M1 || result_request !== 32'h00010203) begin
         n_err++; $display("FAIL hit_result got=%b/%h/%h want=11/%h/00010203",
                           {result_valid, result_hit}, result_message, result_request, M1);
      end
      @(negedge clk);
      n_cmp++;
      if (result_valid !== 1'b0) begin
         n_err++; $display("FAIL hit_pulse got=%b want=0", result_valid);
      end
      repeat (3) @(negedge clk);
      tr = 0;
   endtask

   task automatic test_miss(input logic [31:0] key, input logic exp_terr);
      bit ok; int tf; int stray;
      req_valid = 1'b1; request = key;
      @(negedge clk);
      req_valid = 1'b0;
      wait_sig(1, 50, ok, tf);
      n_cmp++;
      if (!ok) begin
         n_err++; $display("FAIL miss_find got=none want=find");
      end
      repeat (2) @(negedge clk);
      not_found = 1'b1;
      @(negedge clk);
      not_found = 1'b0;
      n_cmp++;
      if ({result_valid, result_hit} !== 2'b10 || result_message !== '0 || result_request !== key) begin
         n_err++; $display("FAIL miss_result got=%b/%h/%h want=10/0/%h",
                           {result_valid, result_hit}, result_message, result_request, key);
      end
      n_cmp++;
      if (timeout_err !== exp_terr) begin
         n_err++; $display("FAIL miss_timeout_err got=%b want=%b", timeout_err, exp_terr);
      end
      stray = 0;
      found = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (result_valid) stray++;
      end
      found = 1'b0;
      n_cmp++;
      if (stray !== 0) begin
         n_err++; $display("FAIL miss_stray_status got=%0d want=0", stray);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_timeout();
      bit ok; int tf, tr;
      req_valid = 1'b1; request = 32'h0000AABB;
      @(negedge clk);
      req_valid = 1'b0;
      wait_sig(1, 50, ok, tf);
      @(negedge clk);
      wait_sig(2, TO + 50, ok, tr);
      n_cmp++;
      if (!ok || (tr - tf) !== TO + 1) begin
         n_err++; $display("FAIL timeout_latency ok=%0d got=%0d want=%0d", ok, tr - tf, TO + 1);
      end
      n_cmp++;
      if ({result_hit, timeout_err} !== 2'b01 || result_message !== '0 || result_request !== 32'h0000AABB) begin
         n_err++; $display("FAIL timeout_result got=%b/%h/%h want=01/0/0000aabb",
                           {result_hit, timeout_err}, result_message, result_request);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_burst();
      int idx, occ, ins, ins_before, nf_at, push_prev;
      bit fnd, saw_low;
      idx = 0; occ = 0; ins = 0; ins_before = -1; nf_at = -1; fnd = 0; saw_low = 0;
      req_valid = 1'b1; request = 32'h00000077;
      net_valid = 1'b1; net_message = nm(0);
      for (int c = 0; c < 200 && !(ins == 6 && fnd); c++) begin
         push_prev = int'(net_valid && net_ready);
         @(negedge clk);
         req_valid = 1'b0;
         idx += push_prev;
         occ = occ + push_prev - int'(insert);
         n_cmp++;
         if (net_ready !== (occ != 4)) begin
            n_err++; $display("FAIL burst_net_ready occ=%0d got=%b want=%b", occ, net_ready, occ != 4);
         end
         if (!net_ready) saw_low = 1'b1;
         if (insert) begin
            n_cmp++;
            if (message !== nm(ins)) begin
               n_err++; $display("FAIL burst_msg_order got=%h want=%h", message, nm(ins));
            end
            ins++;
         end
         if (find) begin
            fnd = 1'b1; ins_before = ins; nf_at = cyc + 1;
         end
         not_found = (cyc == nf_at);
         if (idx < 6) net_message = nm(idx);
         else net_valid = 1'b0;
      end
      not_found = 1'b0; net_valid = 1'b0;
      n_cmp++;
      if (ins_before !== 4 || ins !== 6) begin
         n_err++; $display("FAIL burst_order got=%0d/%0d want=4/6", ins_before, ins);
      end
      n_cmp++;
      if (!saw_low) begin
         n_err++; $display("FAIL burst_full got=ready_always_high want=ready_low_seen");
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_qfull();
      int ins, fnds, nf_at, t0, ti;
      bit ok;
      ins = 0; fnds = 0; nf_at = -1;
      Q_full = 1'b1;
      net_valid = 1'b1; net_message = nm(9);
      req_valid = 1'b1; request = 32'h000012AB;
      @(negedge clk);
      net_valid = 1'b0; req_valid = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (insert) ins++;
         if (find) begin
            fnds++; nf_at = cyc + 1;
         end
         not_found = (cyc == nf_at);
      end
      not_found = 1'b0;
      n_cmp++;
      if (ins !== 0 || fnds !== 1) begin
         n_err++; $display("FAIL qfull_block got=%0d/%0d want=0/1", ins, fnds);
      end
      Q_full = 1'b0;
      t0 = cyc;
      @(negedge clk);
      wait_sig(0, 20, ok, ti);
      n_cmp++;
      if (!ok || (ti - t0) !== 1 || message !== nm(9)) begin
         n_err++; $display("FAIL qfull_resume ok=%0d got=%0d/%h want=1/%h", ok, ti - t0, message, nm(9));
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset_wait();
      bit ok; int tf, stray;
      req_valid = 1'b1; request = 32'h0000BEEF;
      @(negedge clk);
      req_valid = 1'b0;
      wait_sig(1, 50, ok, tf);
      @(negedge clk);
      net_valid = 1'b1; net_message = nm(20);
      @(negedge clk);
      net_message = nm(21);
      @(negedge clk);
      net_valid = 1'b0;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({insert, find, result_valid, result_hit, timeout_err} !== 5'd0 ||
          {result_message, result_request, request_out} !== '0) begin
         n_err++; $display("FAIL rst_wait_outputs got=%b/%h/%h want=0",
                           {insert, find, result_valid, result_hit, timeout_err}, result_request, request_out);
      end
      @(negedge clk);
      rst = 1'b0;
      found = 1'b1; unexpected_message = M1;
      stray = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (i == 2) found = 1'b0;
         if (result_valid || insert || find) stray++;
      end
      n_cmp++;
      if (stray !== 0) begin
         n_err++; $display("FAIL rst_wait_abandon got=%0d want=0", stray);
      end
      n_cmp++;
      if ({net_ready, req_ready} !== 2'b11) begin
         n_err++; $display("FAIL rst_wait_ready got=%b want=11", {net_ready, req_ready});
      end
   endtask

   initial begin
      test_reset();
      test_hit();
      test_miss(32'h00050607, 1'b0);
      test_timeout();
      test_miss(32'h00090A0B, 1'b1);
      test_burst();
      test_qfull();
      test_reset_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/match_issue_arbiter.md
MATCH_ISSUE_ARBITER -- requirements
Module: match_issue_arbiter

Interface
REQ-001 Parameter PKT_WIDTH, default 128: width of network message and result message.
REQ-002 Parameter FIFO_AW, default 2: log2 depth of each input FIFO (depth 4).
REQ-003 Parameter TIMEOUT, default 1100: maximum cycles spent in WAIT_RESULT.
REQ-004 Parameter MAX_BURST, default 4: consecutive inserts allowed while a request waits.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 net_valid  in  1  network message offered.
REQ-008 net_message  in  PKT_WIDTH  router message; [111:104] comm, [103:96] src, [95:88] tag.
REQ-009 net_ready  out  1  net FIFO not full.
REQ-010 req_valid  in  1  host receive request offered.
REQ-011 request  in  32  [23:16] comm, [15:8] src, [7:0] tag.
REQ-012 req_ready  out  1  request FIFO not full.
REQ-013 insert  out  1  one-cycle insert strobe to unexpected queue.
REQ-014 find  out  1  one-cycle search strobe to unexpected queue.
REQ-015 message  out  PKT_WIDTH  payload for insert, valid while insert high.
REQ-016 request_out  out  32  search key, held stable from find until result.
REQ-017 found, not_found, Q_full  in  1 each  queue status.
REQ-018 unexpected_message  in  PKT_WIDTH  matched payload, valid with found.
REQ-019 result_valid  out  1  one-cycle result pulse.
REQ-020 result_hit  out  1  1 = match, 0 = miss or timeout.
REQ-021 result_message  out  PKT_WIDTH  matched payload on hit, else 0.
REQ-022 result_request  out  32  key the result belongs to.
REQ-023 timeout_err  out  1  sticky; set on any search timeout.

Function
REQ-024 Net FIFO and request FIFO are each 2**FIFO_AW deep; a push occurs when valid and ready are both high in a cycle; simultaneous push and pop on a full FIFO is refused (ready reflects full only).
REQ-025 FSM states: IDLE, INS, SETTLE, FIND, WAIT_RESULT.
REQ-026 IDLE: if net FIFO non-empty, Q_full low, and burst count < MAX_BURST, go to INS; else if request FIFO non-empty, go to FIND; else stay in IDLE.
REQ-027 INS: assert insert and message for exactly one cycle, pop net FIFO, increment burst count (saturating), go to SETTLE.
REQ-028 SETTLE: one idle cycle, with no strobes, then back to IDLE, so that queue pointers and count update before the next operation.
REQ-029 FIND: pop request FIFO into request_out register, assert find one cycle, clear burst count and timeout counter, go to WAIT_RESULT.
REQ-030 Burst count clears whenever the request FIFO is empty; when a request waits and burst count = MAX_BURST, FIND takes priority over INS.
REQ-031 WAIT_RESULT: insert and find held low; on found, emit result_valid=1, result_hit=1, result_message=unexpected_message; on not_found, emit result_valid=1, result_hit=0, result_message=0; either way go to SETTLE.
REQ-032 found and not_found high together: treat as found.
REQ-033 Timeout counter counts cycles in WAIT_RESULT; when it reaches TIMEOUT with no status, emit result_valid=1 with hit=0, set timeout_err, and go to SETTLE (this covers searches of an empty queue that return no status).
REQ-034 result_request equals request_out on every result_valid cycle.
REQ-035 Q_full high blocks INS only; FIND proceeds.
REQ-036 insert and find are never high in the same cycle; at most one operation is outstanding.
REQ-037 found or not_found outside WAIT_RESULT are ignored.

Reset
REQ-038 Asserting rst at any time forces immediately: FSM to IDLE, both FIFOs empty, counters to 0, insert=find=0, result_valid=0, result_hit=0, result_message=0, result_request=0, request_out=0, timeout_err=0, net_ready=req_ready=1 (after reset released); any in-flight search is abandoned without a result.

Verification
REQ-039 Net message with comm/src/tag 0x01/0x02/0x03, then request 0x00010203 -> insert pulse at cycle N, find no earlier than N+2, found -> result_valid, hit=1, result_message = message, result_request = 0x00010203.
REQ-040 Request 0x00050607 with not_found returned 3 cycles after find -> result_valid, hit=0, result_message=0, timeout_err=0.
REQ-041 Request with no status returned -> result_valid hit=0 exactly TIMEOUT cycles into WAIT_RESULT, timeout_err=1 and stays 1 until rst.
REQ-042 Six net messages queued and a request pending -> four inserts, then the find, then the remaining inserts; net_ready=0 while the net FIFO holds 4 entries.
REQ-043 Q_full=1 with net and request pending -> no insert; find is issued; inserts resume one cycle after Q_full falls.
REQ-044 rst pulsed during WAIT_RESULT -> outputs at reset values immediately; no result_valid afterwards for the abandoned search; FIFOs empty.
